// File: rtl/lbus_protocol_checker_pkg.sv
// Shared types and the per-segment framing step for the LBUS protocol checker.
// The top module and the per-segment stage both import this package.
package lbus_protocol_checker_pkg;

    localparam int ERR_W = 7;
    localparam int LEN_W = 32;

    localparam int SOP_IN_PKT  = 0;
    localparam int EOP_NO_PKT  = 1;
    localparam int DATA_NO_PKT = 2;
    localparam int SEG_GAP     = 3;
    localparam int MTY_NOT_EOP = 4;
    localparam int LEN_SHORT   = 5;
    localparam int LEN_LONG    = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_e;

    // pkt_err remembers segment-level errors of the open packet so its EOP is not counted clean
    typedef struct packed {
        state_e             state;
        logic [LEN_W-1:0]   len;
        logic               pkt_err;
    } frame_t;

    typedef struct packed {
        frame_t             nxt;
        logic [ERR_W-1:0]   err;
        logic               clean;
    } step_t;

    function automatic step_t seg_step(
        input frame_t           cur,
        input logic             ena,
        input logic             sop,
        input logic             eop,
        input logic             gap,
        input logic [LEN_W-1:0] mty,
        input logic [LEN_W-1:0] seg_bytes,
        input logic [LEN_W-1:0] mtu_min,
        input logic [LEN_W-1:0] mtu_max
    );
        step_t            r;
        logic [LEN_W-1:0] base;
        logic [LEN_W-1:0] raw;
        logic             in_pkt;
        r      = '0;
        r.nxt  = cur;
        base   = '0;
        raw    = '0;
        in_pkt = 1'b0;
        if (ena) begin
            r.err[SEG_GAP]     = gap;
            r.err[MTY_NOT_EOP] = (mty != '0) && !eop;
            if (cur.state == IN_PKT) begin
                in_pkt = 1'b1;
                if (sop) begin
                    r.err[SOP_IN_PKT] = 1'b1;
                    base              = '0;
                    r.nxt.pkt_err     = 1'b0;
                end else begin
                    base = cur.len;
                end
            end else if (sop) begin
                in_pkt        = 1'b1;
                base          = '0;
                r.nxt.pkt_err = 1'b0;
            end else if (eop) begin
                r.err[EOP_NO_PKT] = 1'b1;
            end else begin
                r.err[DATA_NO_PKT] = 1'b1;
            end

            if (in_pkt) begin
                // a base already past MTU_MAX is saturated and must stay long after MTY is removed
                raw = base + seg_bytes - (eop ? mty : '0);
                if ((base > mtu_max) || (raw > mtu_max)) begin
                    r.nxt.len = mtu_max + LEN_W'(1);
                end else begin
                    r.nxt.len = raw;
                end
                if (eop) begin
                    r.err[LEN_SHORT] = (r.nxt.len < mtu_min);
                    r.err[LEN_LONG]  = (r.nxt.len > mtu_max);
                    r.clean          = !(r.nxt.pkt_err | gap | r.err[MTY_NOT_EOP] |
                                         r.err[LEN_SHORT] | r.err[LEN_LONG]);
                    r.nxt.state      = IDLE;
                    r.nxt.pkt_err    = 1'b0;
                end else begin
                    r.nxt.state   = IN_PKT;
                    r.nxt.pkt_err = r.nxt.pkt_err | gap | r.err[MTY_NOT_EOP];
                end
            end else begin
                r.nxt.len = cur.len;
            end
        end else begin
            r.nxt = cur;
        end
        return r;
    endfunction

endpackage

// File: rtl/lbus_check_seg.sv
// Combinational evaluation of one LBUS segment against the framing state
// handed over by the previous segment of the same beat.
module lbus_check_seg
    import lbus_protocol_checker_pkg::*;
#(
    parameter int SEG_BYTES = 16,
    parameter int MTU_MIN   = 60,
    parameter int MTU_MAX   = 16383,
    localparam int MTY_W    = $clog2(SEG_BYTES)
) (
    input  frame_t             cur,
    input  logic               ena,
    input  logic               sop,
    input  logic               eop,
    input  logic               gap,
    input  logic [MTY_W-1:0]   mty,
    output frame_t             nxt,
    output logic [ERR_W-1:0]   err,
    output logic               clean
);

    step_t step_s;

    // single segment step
    always_comb begin
        step_s = seg_step(cur, ena, sop, eop, gap, LEN_W'(mty),
                          LEN_W'(SEG_BYTES), LEN_W'(MTU_MIN), LEN_W'(MTU_MAX));
    end

    assign nxt   = step_s.nxt;
    assign err   = step_s.err;
    assign clean = step_s.clean;

endmodule

// File: rtl/lbus_protocol_checker.sv
// Passive LBUS framing and length checker: chains one stage per segment and
// registers per-beat error reports, sticky flags and packet/error counters.
module lbus_protocol_checker
    import lbus_protocol_checker_pkg::*;
#(
    parameter int SEGMENTS  = 4,
    parameter int SEG_BYTES = 16,
    parameter int MTU_MIN   = 60,
    parameter int MTU_MAX   = 16383,
    parameter int CNT_WIDTH = 32,
    localparam int MTY_W    = $clog2(SEG_BYTES)
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      LBUS_RDY,
    input  logic [SEGMENTS-1:0]       LBUS_ENA,
    input  logic [SEGMENTS-1:0]       LBUS_SOP,
    input  logic [SEGMENTS-1:0]       LBUS_EOP,
    input  logic [SEGMENTS*MTY_W-1:0] LBUS_MTY,
    input  logic                      CLEAR,
    output logic                      ERR_PULSE,
    output logic [ERR_W-1:0]          ERR_CODE,
    output logic [ERR_W-1:0]          ERR_STICKY,
    output logic [CNT_WIDTH-1:0]      PKT_CNT,
    output logic [CNT_WIDTH-1:0]      ERR_CNT
);

    frame_t                 frame_r;
    logic                   err_pulse_r;
    logic [ERR_W-1:0]       err_code_r;
    logic [ERR_W-1:0]       err_sticky_r;
    logic [CNT_WIDTH-1:0]   pkt_cnt_r;
    logic [CNT_WIDTH-1:0]   err_cnt_r;

    logic                   beat_s;
    logic [SEGMENTS-1:0]    gap_s;
    logic [SEGMENTS-1:0]    clean_s;
    logic [ERR_W-1:0]       seg_err_s [SEGMENTS];
    logic [ERR_W-1:0]       beat_err_s;
    logic [CNT_WIDTH-1:0]   clean_cnt_s;

    assign beat_s = LBUS_RDY & (|LBUS_ENA);

    // a valid segment above any disabled one is a gap
    always_comb begin
        logic seen_off;
        seen_off = 1'b0;
        gap_s    = '0;
        for (int i = 0; i < SEGMENTS; i++) begin
            gap_s[i] = LBUS_ENA[i] & seen_off;
            seen_off = seen_off | ~LBUS_ENA[i];
        end
    end

    for (genvar i = 0; i < SEGMENTS; i++) begin : g_seg
        frame_t cur_s;
        frame_t nxt_s;
        if (i == 0) begin : g_first
            assign cur_s = frame_r;
        end else begin : g_next
            assign cur_s = g_seg[i-1].nxt_s;
        end
        lbus_check_seg #(
            .SEG_BYTES (SEG_BYTES),
            .MTU_MIN   (MTU_MIN),
            .MTU_MAX   (MTU_MAX)
        ) u_seg (
            .cur   (cur_s),
            .ena   (LBUS_ENA[i]),
            .sop   (LBUS_SOP[i]),
            .eop   (LBUS_EOP[i]),
            .gap   (gap_s[i]),
            .mty   (LBUS_MTY[i*MTY_W +: MTY_W]),
            .nxt   (nxt_s),
            .err   (seg_err_s[i]),
            .clean (clean_s[i])
        );
    end

    // merge per-segment errors and count clean packet ends
    always_comb begin
        beat_err_s  = '0;
        clean_cnt_s = '0;
        for (int i = 0; i < SEGMENTS; i++) begin
            beat_err_s  = beat_err_s | seg_err_s[i];
            clean_cnt_s = clean_cnt_s + CNT_WIDTH'(clean_s[i]);
        end
    end

    // framing state and reporting registers; CLEAR only zeroes sticky flags and counters
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_r      <= '{state: IDLE, len: '0, pkt_err: 1'b0};
            err_pulse_r  <= 1'b0;
            err_code_r   <= '0;
            err_sticky_r <= '0;
            pkt_cnt_r    <= '0;
            err_cnt_r    <= '0;
        end else begin
            err_pulse_r <= beat_s & (|beat_err_s);
            err_code_r  <= beat_s ? beat_err_s : '0;
            if (beat_s) begin
                frame_r <= g_seg[SEGMENTS-1].nxt_s;
            end else begin
                frame_r <= frame_r;
            end
            if (CLEAR) begin
                err_sticky_r <= '0;
                pkt_cnt_r    <= '0;
                err_cnt_r    <= '0;
            end else if (beat_s) begin
                err_sticky_r <= err_sticky_r | beat_err_s;
                pkt_cnt_r    <= pkt_cnt_r + clean_cnt_s;
                err_cnt_r    <= err_cnt_r + CNT_WIDTH'(|beat_err_s);
            end else begin
                err_sticky_r <= err_sticky_r;
                pkt_cnt_r    <= pkt_cnt_r;
                err_cnt_r    <= err_cnt_r;
            end
        end
    end

    assign ERR_PULSE  = err_pulse_r;
    assign ERR_CODE   = err_code_r;
    assign ERR_STICKY = err_sticky_r;
    assign PKT_CNT    = pkt_cnt_r;
    assign ERR_CNT    = err_cnt_r;

endmodule
